lcd_regs: RTL and testbench

- Memory-mapped responder for the CPU external bus (mem_re, mem_we, addr_ext, data bus) that owns the LCD timing registers FF40–FF45.
- Generates the line/dot timing, LY, STAT mode and coincidence flag, plus V-blank and STAT interrupt request pulses.
- Replaces the ad-hoc FF44 counter in the top level; its read data feeds the top-level data_ext mux.

---
 rtl/lcd_regs.sv | 196 +++++++++++++++++++
 tb/tb_lcd_regs.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_regs.sv
// LCD timing register block (FF40-FF45): dot/line timing, STAT mode, LYC coincidence and IRQ pulses.
// Optional window registers FF4A/FF4B are included when LCD_REGS_WINDOW_EN is defined.
module lcd_regs #(
  parameter int LINE_CYCLES   = 456,
  parameter int OAM_CYCLES    = 80,
  parameter int XFER_CYCLES   = 172,
  parameter int VISIBLE_LINES = 144,
  parameter int TOTAL_LINES   = 154
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cpu_tick,
  input  logic [15:0] addr_ext,
  input  logic        mem_re,
  input  logic        mem_we,
  input  logic [7:0]  data_in,
  output logic [7:0]  data_out,
  output logic        data_oe,
  output logic [7:0]  ly,
  output logic [1:0]  mode,
  output logic        vblank_irq,
  output logic        stat_irq
`ifdef LCD_REGS_WINDOW_EN
  ,
  output logic [7:0]  wy,
  output logic [7:0]  wx
`endif
);

  localparam logic [8:0] DOT_LAST    = 9'(LINE_CYCLES - 1);
  localparam logic [8:0] XFER_START  = 9'(OAM_CYCLES);
  localparam logic [8:0] HBL_START   = 9'(OAM_CYCLES + XFER_CYCLES);
  localparam logic [7:0] LY_LAST     = 8'(TOTAL_LINES - 1);
  localparam logic [7:0] VBL_FIRST   = 8'(VISIBLE_LINES);
  localparam logic [7:0] VBL_PREV    = 8'(VISIBLE_LINES - 1);

  localparam logic [1:0] MODE_HBLANK = 2'd0;
  localparam logic [1:0] MODE_VBLANK = 2'd1;
  localparam logic [1:0] MODE_OAM    = 2'd2;
  localparam logic [1:0] MODE_XFER   = 2'd3;

  logic [7:0] lcdc_q, lcdc_d;
  logic [3:0] stat_en_q, stat_en_d;
  logic [7:0] scy_q, scy_d, scx_q, scx_d, lyc_q, lyc_d;
  logic [8:0] dot_q, dot_d;
  logic [7:0] ly_q, ly_d;
  logic       stat_line_q, stat_line_d;
  logic       vblank_irq_q, vblank_irq_d;
  logic       stat_irq_q, stat_irq_d;
`ifdef LCD_REGS_WINDOW_EN
  logic [7:0] wy_q, wy_d, wx_q, wx_d;
`endif

  logic       hit;
  logic       coinc;
  logic [1:0] mode_cur;
  logic       stat_line_now;
  logic       wr_en;

  assign coinc = (ly_q == lyc_q);
  assign wr_en = cpu_tick & mem_we;

  always_comb begin
    mode_cur = MODE_HBLANK;
    if (!lcdc_q[7])             mode_cur = MODE_HBLANK;
    else if (ly_q >= VBL_FIRST) mode_cur = MODE_VBLANK;
    else if (dot_q < XFER_START) mode_cur = MODE_OAM;
    else if (dot_q < HBL_START) mode_cur = MODE_XFER;
    else                        mode_cur = MODE_HBLANK;
  end

  // With the LCD off the interrupt line is held low so no request can fire.
  assign stat_line_now = lcdc_q[7] & ((stat_en_q[3] & coinc) |
                                      (stat_en_q[2] & (mode_cur == MODE_OAM)) |
                                      (stat_en_q[1] & (mode_cur == MODE_VBLANK)) |
                                      (stat_en_q[0] & (mode_cur == MODE_HBLANK)));

  always_comb begin
    hit      = 1'b1;
    data_out = 8'h00;
    case (addr_ext)
      16'hFF40: data_out = lcdc_q;
      16'hFF41: data_out = {1'b1, stat_en_q, coinc, mode_cur};
      16'hFF42: data_out = scy_q;
      16'hFF43: data_out = scx_q;
      16'hFF44: data_out = ly_q;
      16'hFF45: data_out = lyc_q;
`ifdef LCD_REGS_WINDOW_EN
      16'hFF4A: data_out = wy_q;
      16'hFF4B: data_out = wx_q;
`endif
      default: begin
        hit      = 1'b0;
        data_out = 8'h00;
      end
    endcase
  end

  assign data_oe = reset & mem_re & hit;

  always_comb begin
    lcdc_d       = lcdc_q;
    stat_en_d    = stat_en_q;
    scy_d        = scy_q;
    scx_d        = scx_q;
    lyc_d        = lyc_q;
    dot_d        = dot_q;
    ly_d         = ly_q;
    stat_line_d  = stat_line_q;
    vblank_irq_d = 1'b0;
    stat_irq_d   = 1'b0;
`ifdef LCD_REGS_WINDOW_EN
    wy_d         = wy_q;
    wx_d         = wx_q;
`endif
    if (cpu_tick) begin
      if (wr_en) begin
        case (addr_ext)
          16'hFF40: lcdc_d    = data_in;
          16'hFF41: stat_en_d = data_in[6:3];
          16'hFF42: scy_d     = data_in;
          16'hFF43: scx_d     = data_in;
          16'hFF45: lyc_d     = data_in;
`ifdef LCD_REGS_WINDOW_EN
          16'hFF4A: wy_d      = data_in;
          16'hFF4B: wx_d      = data_in;
`endif
          default: ;
        endcase
      end
      // Counting needs the LCD on both before and after this tick, so a re-enable starts at dot 0.
      if (lcdc_q[7] & lcdc_d[7]) begin
        if (dot_q == DOT_LAST) begin
          dot_d = 9'd0;
          ly_d  = (ly_q == LY_LAST) ? 8'd0 : ly_q + 8'd1;
        end else begin
          dot_d = dot_q + 9'd1;
        end
      end else begin
        dot_d = 9'd0;
        ly_d  = 8'd0;
      end
      if (wr_en && addr_ext == 16'hFF44) begin
        dot_d = 9'd0;
        ly_d  = 8'd0;
      end
      stat_line_d  = stat_line_now;
      stat_irq_d   = stat_line_now & ~stat_line_q;
      vblank_irq_d = (ly_q == VBL_PREV) & (ly_d == VBL_FIRST);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      lcdc_q       <= 8'h91;
      stat_en_q    <= 4'h0;
      scy_q        <= 8'h00;
      scx_q        <= 8'h00;
      lyc_q        <= 8'h00;
      dot_q        <= 9'd0;
      ly_q         <= 8'd0;
      stat_line_q  <= 1'b0;
      vblank_irq_q <= 1'b0;
      stat_irq_q   <= 1'b0;
`ifdef LCD_REGS_WINDOW_EN
      wy_q         <= 8'h00;
      wx_q         <= 8'h00;
`endif
    end else begin
      lcdc_q       <= lcdc_d;
      stat_en_q    <= stat_en_d;
      scy_q        <= scy_d;
      scx_q        <= scx_d;
      lyc_q        <= lyc_d;
      dot_q        <= dot_d;
      ly_q         <= ly_d;
      stat_line_q  <= stat_line_d;
      vblank_irq_q <= vblank_irq_d;
      stat_irq_q   <= stat_irq_d;
`ifdef LCD_REGS_WINDOW_EN
      wy_q         <= wy_d;
      wx_q         <= wx_d;
`endif
    end
  end

  assign ly         = ly_q;
  assign mode       = mode_cur;
  assign vblank_irq = vblank_irq_q;
  assign stat_irq   = stat_irq_q;
`ifdef LCD_REGS_WINDOW_EN
  assign wy         = wy_q;
  assign wx         = wx_q;
`endif

endmodule

// File: tb/tb_lcd_regs.sv
// Testbench for lcd_regs: scenario tasks checked against a frame-position reference model.
// Window registers are exercised when LCD_REGS_WINDOW_EN is defined.
module tb_lcd_regs;
  localparam int LINE  = 456;
  localparam int FRAME = 456 * 154;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        cpu_tick = 1'b0;
  logic [15:0] addr_ext = 16'h0000;
  logic        mem_re = 1'b0;
  logic        mem_we = 1'b0;
  logic [7:0]  data_in = 8'h00;
  logic [7:0]  data_out;
  logic        data_oe;
  logic [7:0]  ly;
  logic [1:0]  mode;
  logic        vblank_irq;
  logic        stat_irq;
`ifdef LCD_REGS_WINDOW_EN
  logic [7:0]  wy, wx;
`endif

  lcd_regs dut (
    .clock(clock), .reset(reset), .cpu_tick(cpu_tick), .addr_ext(addr_ext),
    .mem_re(mem_re), .mem_we(mem_we), .data_in(data_in), .data_out(data_out),
    .data_oe(data_oe), .ly(ly), .mode(mode), .vblank_irq(vblank_irq), .stat_irq(stat_irq)
`ifdef LCD_REGS_WINDOW_EN
    , .wy(wy), .wx(wx)
`endif
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int irq_diff = 0;
  int vb_seen = 0;
  int st_seen = 0;

  // Reference model: the whole frame is one position counter; LY and dot are derived from it.
  int         m_pos;
  logic [7:0] m_lcdc, m_scy, m_scx, m_lyc, m_wy, m_wx;
  logic [3:0] m_stat_en;
  logic       m_prev;

  function automatic int m_ly();
    return m_pos / LINE;
  endfunction

  function automatic int m_dot();
    return m_pos % LINE;
  endfunction

  function automatic logic [1:0] m_mode();
    if (!m_lcdc[7]) return 2'd0;
    if (m_ly() >= 144) return 2'd1;
    if (m_dot() < 80) return 2'd2;
    if (m_dot() < 252) return 2'd3;
    return 2'd0;
  endfunction

  function automatic logic m_line();
    logic c;
    logic [1:0] md;
    c  = (m_ly() == int'(m_lyc));
    md = m_mode();
    return m_lcdc[7] && ((m_stat_en[3] && c) || (m_stat_en[2] && md == 2'd2) ||
                         (m_stat_en[1] && md == 2'd1) || (m_stat_en[0] && md == 2'd0));
  endfunction

  function automatic void m_read(input logic [15:0] a, output logic [7:0] d, output logic oe);
    oe = 1'b1;
    case (a)
      16'hFF40: d = m_lcdc;
      16'hFF41: d = {1'b1, m_stat_en, m_ly() == int'(m_lyc), m_mode()};
      16'hFF42: d = m_scy;
      16'hFF43: d = m_scx;
      16'hFF44: d = 8'(m_ly());
      16'hFF45: d = m_lyc;
`ifdef LCD_REGS_WINDOW_EN
      16'hFF4A: d = m_wy;
      16'hFF4B: d = m_wx;
`endif
      default: begin d = 8'h00; oe = 1'b0; end
    endcase
  endfunction

  function automatic void m_reset();
    m_pos = 0; m_lcdc = 8'h91; m_stat_en = 4'h0; m_scy = 8'h00; m_scx = 8'h00;
    m_lyc = 8'h00; m_wy = 8'h00; m_wx = 8'h00; m_prev = 1'b0;
  endfunction

  // One clock: drive at posedge+1, advance the model, tally IRQ disagreements.
  task automatic step(input logic tk, input logic we, input logic [15:0] a, input logic [7:0] d);
    logic [7:0] nl;
    int old_ly;
    logic sl, e_vb, e_st;
    cpu_tick = tk; mem_we = we; addr_ext = a; data_in = d;
    e_vb = 1'b0; e_st = 1'b0;
    @(posedge clock); #1;
    if (tk) begin
      old_ly = m_ly();
      sl = m_line();
      e_st = sl && !m_prev;
      m_prev = sl;
      nl = (we && a == 16'hFF40) ? d : m_lcdc;
      if (m_lcdc[7] && nl[7]) m_pos = (m_pos + 1) % FRAME;
      else m_pos = 0;
      if (we) begin
        case (a)
          16'hFF40: m_lcdc = d;
          16'hFF41: m_stat_en = d[6:3];
          16'hFF42: m_scy = d;
          16'hFF43: m_scx = d;
          16'hFF44: m_pos = 0;
          16'hFF45: m_lyc = d;
`ifdef LCD_REGS_WINDOW_EN
          16'hFF4A: m_wy = d;
          16'hFF4B: m_wx = d;
`endif
          default: ;
        endcase
      end
      e_vb = (old_ly == 143) && (m_ly() == 144);
    end
    if (vblank_irq !== e_vb || stat_irq !== e_st) irq_diff++;
    if (vblank_irq === 1'b1) vb_seen++;
    if (stat_irq === 1'b1) st_seen++;
    cpu_tick = 1'b0; mem_we = 1'b0; addr_ext = 16'h0000;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 16'h0000, 8'h00);
  endtask

  task automatic rd(input logic [15:0] a, output logic [7:0] d, output logic oe);
    addr_ext = a; mem_re = 1'b1;
    #1;
    d = data_out; oe = data_oe;
    mem_re = 1'b0; addr_ext = 16'h0000;
  endtask

  task automatic test_reset();
    logic [7:0] d;
    logic oe;
    reset = 1'b0; cpu_tick = 1'b1; mem_we = 1'b1; mem_re = 1'b1;
    addr_ext = 16'hFF40; data_in = 8'h00;
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if (data_oe !== 1'b0 || vblank_irq !== 1'b0 || stat_irq !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got oe=%b vb=%b st=%b required 0 0 0", data_oe, vblank_irq, stat_irq);
    end
    reset = 1'b1; cpu_tick = 1'b0; mem_we = 1'b0; mem_re = 1'b0; addr_ext = 16'h0000;
    m_reset();
    rd(16'hFF40, d, oe);
    checks++;
    if (d !== 8'h91 || oe !== 1'b1) begin errors++; $display("FAIL reset_lcdc: got %h oe=%b required 91 oe=1", d, oe); end
    rd(16'hFF41, d, oe);
    checks++;
    if (d !== 8'h86) begin errors++; $display("FAIL reset_stat: got %h required 86", d); end
    rd(16'hFF44, d, oe);
    checks++;
    if (d !== 8'h00 || ly !== 8'h00 || mode !== 2'd2) begin
      errors++; $display("FAIL reset_ly: got %h ly=%h mode=%0d required 00 00 2", d, ly, mode);
    end
    rd(16'hFF46, d, oe);
    checks++;
    if (d !== 8'h00 || oe !== 1'b0) begin errors++; $display("FAIL undecoded_read: got %h oe=%b required 00 oe=0", d, oe); end
  endtask

  task automatic test_line_timing();
    checks++;
    if (mode !== 2'd2) begin errors++; $display("FAIL mode_dot0: got %0d required 2", mode); end
    run(80);
    checks++;
    if (mode !== 2'd3) begin errors++; $display("FAIL mode_dot80: got %0d required 3", mode); end
    run(172);
    checks++;
    if (mode !== 2'd0) begin errors++; $display("FAIL mode_dot252: got %0d required 0", mode); end
    run(203);
    checks++;
    if (mode !== 2'd0 || ly !== 8'd0) begin errors++; $display("FAIL mode_dot455: got mode=%0d ly=%0d required 0 0", mode, ly); end
    run(1);
    checks++;
    if (ly !== 8'd1 || mode !== 2'd2) begin errors++; $display("FAIL line_advance: got ly=%0d mode=%0d required 1 2", ly, mode); end
  endtask

  task automatic test_frame();
    int vb0;
    vb0 = vb_seen;
    run(143 * LINE);
    checks++;
    if (ly !== 8'd144 || mode !== 2'd1 || vb_seen - vb0 != 1) begin
      errors++; $display("FAIL vblank_entry: got ly=%0d mode=%0d pulses=%0d required 144 1 1", ly, mode, vb_seen - vb0);
    end
    run(10 * LINE);
    checks++;
    if (ly !== 8'd0 || mode !== 2'd2 || vb_seen - vb0 != 1) begin
      errors++; $display("FAIL frame_wrap: got ly=%0d mode=%0d pulses=%0d required 0 2 1", ly, mode, vb_seen - vb0);
    end
    checks++;
    if (irq_diff != 0) begin errors++; $display("FAIL irq_frame: got %0d irq mismatches required 0", irq_diff); end
  endtask

  task automatic test_stat_coinc();
    int st0;
    logic [7:0] d;
    logic oe;
    step(1'b1, 1'b1, 16'hFF45, 8'd5);
    step(1'b1, 1'b1, 16'hFF41, 8'h40);
    st0 = st_seen;
    for (int i = 0; i < 6 * LINE && m_ly() != 5; i++) run(1);
    run(10);
    rd(16'hFF41, d, oe);
    checks++;
    if (ly !== 8'd5 || st_seen - st0 != 1 || d[2] !== 1'b1) begin
      errors++; $display("FAIL lyc_irq: got ly=%0d pulses=%0d stat=%h required 5 1 bit2=1", ly, st_seen - st0, d);
    end
    step(1'b1, 1'b1, 16'hFF41, 8'h48);
    run(400);
    checks++;
    if (st_seen - st0 != 1 || mode !== 2'd0) begin
      errors++; $display("FAIL stat_no_repulse: got pulses=%0d mode=%0d required 1 0", st_seen - st0, mode);
    end
    checks++;
    if (irq_diff != 0) begin errors++; $display("FAIL irq_stat: got %0d irq mismatches required 0", irq_diff); end
  endtask

  task automatic test_ly_write();
    logic [7:0] d;
    logic oe;
    for (int i = 0; i < 20000 && !(m_ly() == 20 && m_dot() == 200); i++) run(1);
    step(1'b1, 1'b1, 16'hFF44, 8'h7F);
    rd(16'hFF44, d, oe);
    checks++;
    if (d !== 8'h00 || ly !== 8'd0 || mode !== 2'd2) begin
      errors++; $display("FAIL ly_write: got ly=%h mode=%0d required 00 2", d, mode);
    end
    run(455);
    step(1'b1, 1'b1, 16'hFF44, 8'h00);
    checks++;
    if (ly !== 8'd0 || mode !== 2'd2) begin
      errors++; $display("FAIL ly_write_at_wrap: got ly=%0d mode=%0d required 0 2", ly, mode);
    end
    run(80);
    checks++;
    if (ly !== 8'd0 || mode !== 2'd3) begin
      errors++; $display("FAIL dot_cleared: got ly=%0d mode=%0d required 0 3", ly, mode);
    end
  endtask

  task automatic test_lcd_off();
    int vb0, st0, bad;
    logic [7:0] d;
    logic oe;
    vb0 = vb_seen; st0 = st_seen; bad = 0;
    step(1'b1, 1'b1, 16'hFF40, 8'h11);
    for (int i = 0; i < 10; i++) begin
      run(100);
      checks++;
      if (ly !== 8'd0 || mode !== 2'd0) begin
        errors++; $display("FAIL lcd_off_hold: got ly=%0d mode=%0d required 0 0", ly, mode);
      end
    end
    checks++;
    if (vb_seen != vb0 || st_seen != st0) begin
      errors++; $display("FAIL lcd_off_irq: got vb=%0d st=%0d new pulses required 0 0", vb_seen - vb0, st_seen - st0);
    end
    step(1'b1, 1'b1, 16'hFF40, 8'h91);
    rd(16'hFF40, d, oe);
    checks++;
    if (d !== 8'h91 || ly !== 8'd0 || mode !== 2'd2) begin
      errors++; $display("FAIL lcd_reenable: got lcdc=%h ly=%0d mode=%0d required 91 0 2", d, ly, mode);
    end
    run(80);
    checks++;
    if (ly !== 8'd0 || mode !== 2'd3) begin
      errors++; $display("FAIL reenable_dot0: got ly=%0d mode=%0d required 0 3", ly, mode);
    end
  endtask

  task automatic test_random();
    logic [15:0] addrs [10];
    logic [15:0] a;
    logic [7:0] d, ed;
    logic oe, eoe, tk, we;
    addrs = '{16'hFF40, 16'hFF41, 16'hFF42, 16'hFF43, 16'hFF44, 16'hFF45,
              16'hFF46, 16'hFF4A, 16'hFF4B, 16'h8000};
    for (int i = 0; i < 600; i++) begin
      a = addrs[$urandom_range(0, 9)];
      rd(a, d, oe);
      m_read(a, ed, eoe);
      checks++;
      if (d !== ed || oe !== eoe) begin
        errors++; $display("FAIL rand_read[%0d]: addr %h got %h oe=%b required %h oe=%b", i, a, d, oe, ed, eoe);
      end
      checks++;
      if (ly !== 8'(m_ly()) || mode !== m_mode()) begin
        errors++; $display("FAIL rand_state[%0d]: got ly=%0d mode=%0d required %0d %0d", i, ly, mode, m_ly(), m_mode());
      end
      a  = addrs[$urandom_range(0, 9)];
      d  = 8'($urandom);
      if (a == 16'hFF40 && $urandom_range(0, 3) != 0) d[7] = 1'b1;
      tk = ($urandom_range(0, 9) < 7);
      we = ($urandom_range(0, 9) < 3);
      step(tk, we, a, d);
    end
    checks++;
    if (irq_diff != 0) begin errors++; $display("FAIL irq_random: got %0d irq mismatches required 0", irq_diff); end
  endtask

  task automatic test_window();
    logic [7:0] d;
    logic oe;
`ifdef LCD_REGS_WINDOW_EN
    step(1'b1, 1'b1, 16'hFF4A, 8'h10);
    step(1'b1, 1'b1, 16'hFF4B, 8'h07);
    rd(16'hFF4A, d, oe);
    checks++;
    if (d !== 8'h10 || oe !== 1'b1 || wy !== 8'h10) begin
      errors++; $display("FAIL wy_rw: got %h oe=%b port=%h required 10 1 10", d, oe, wy);
    end
    rd(16'hFF4B, d, oe);
    checks++;
    if (d !== 8'h07 || oe !== 1'b1 || wx !== 8'h07) begin
      errors++; $display("FAIL wx_rw: got %h oe=%b port=%h required 07 1 07", d, oe, wx);
    end
`else
    step(1'b1, 1'b1, 16'hFF4A, 8'h10);
    rd(16'hFF4A, d, oe);
    checks++;
    if (d !== 8'h00 || oe !== 1'b0) begin errors++; $display("FAIL wy_undecoded: got %h oe=%b required 00 0", d, oe); end
    rd(16'hFF4B, d, oe);
    checks++;
    if (d !== 8'h00 || oe !== 1'b0) begin errors++; $display("FAIL wx_undecoded: got %h oe=%b required 00 0", d, oe); end
`endif
  endtask

  initial begin
    m_reset();
    #1;
    test_reset();
    test_line_timing();
    test_frame();
    test_stat_coinc();
    test_ly_write();
    test_lcd_off();
    test_window();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
